// File: rtl/cave_download_pkg.sv
// cave_download_pkg: shared constants and lane helpers for the ROM download packer.
// Contents:
//   LANES, WORD_BITS, MASK_BITS - geometry of one 64-bit DDR word built from 16-bit lanes
//   WADDR_W                     - width of the 8-byte word address taken from download_addr[26:3]
//   DDR_ROM_BASE                - default byte base address of the ROM image in DDR
//   lane_mask/lane_data/lane_sel - place a 16-bit lane into a 64-bit word and its byte mask
package cave_download_pkg;
    localparam int LANES = 4;
    localparam int WORD_BITS = 64;
    localparam int MASK_BITS = WORD_BITS / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int WADDR_W = 24;
    localparam logic [31:0] DDR_ROM_BASE = 32'h3000_0000;

    function automatic logic [MASK_BITS-1:0] lane_mask(input logic [LANE_W-1:0] lane);
        return 8'b0000_0011 << {lane, 1'b0};
    endfunction

    function automatic logic [WORD_BITS-1:0] lane_data(input logic [LANE_W-1:0] lane, input logic [15:0] d);
        return 64'(d) << {lane, 4'b0000};
    endfunction

    function automatic logic [WORD_BITS-1:0] lane_sel(input logic [LANE_W-1:0] lane);
        return 64'h0000_0000_0000_FFFF << {lane, 4'b0000};
    endfunction
endpackage

// File: rtl/download_packer.sv
// download_packer: packs 16-bit ROM download writes into masked 64-bit DDR write requests.
// Ports:
//   clock, reset                 - rising-edge clock, asynchronous active-high reset
//   download_cs/wr/index/addr/dout - download source; addr bit 0 ignored, lane = addr[2:1]
//   download_waitReq             - stall to the source (input latch occupied or flush pending)
//   mem_wr/addr/din/mask         - 64-bit write request, held stable while mem_waitReq=1
//   mem_waitReq                  - sink stall
//   busy                         - latch, accumulator or output register holds data
//   done                         - one-cycle pulse when a download has fully drained
//   error                        - sticky: a write arrived while download_waitReq=1
module download_packer
    import cave_download_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DDR_ROM_BASE,
    parameter logic [7:0]  ROM_INDEX = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        download_cs,
    input  logic        download_wr,
    input  logic [7:0]  download_index,
    input  logic [26:0] download_addr,
    input  logic [15:0] download_dout,
    output logic        download_waitReq,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_din,
    output logic [7:0]  mem_mask,
    input  logic        mem_waitReq,
    output logic        busy,
    output logic        done,
    output logic        error
);
    logic                 lat_v_q, lat_v_d;
    logic [WADDR_W-1:0]   lat_waddr_q, lat_waddr_d;
    logic [LANE_W-1:0]    lat_lane_q, lat_lane_d;
    logic [15:0]          lat_data_q, lat_data_d;
    logic [WADDR_W-1:0]   acc_waddr_q, acc_waddr_d;
    logic [WORD_BITS-1:0] acc_data_q, acc_data_d;
    logic [MASK_BITS-1:0] acc_mask_q, acc_mask_d;
    logic                 out_v_q, out_v_d;
    logic [WADDR_W-1:0]   out_waddr_q, out_waddr_d;
    logic [WORD_BITS-1:0] out_data_q, out_data_d;
    logic [MASK_BITS-1:0] out_mask_q, out_mask_d;
    logic                 cs_q;
    logic                 flush_q, flush_d;
    logic                 error_q, error_d;

    logic                 acc_v, out_free, hit, accept, merge_ok, empty_all;
    logic [MASK_BITS-1:0] ins_mask, m_mask;
    logic [WORD_BITS-1:0] ins_data, m_data;
    logic                 unused_addr0;

    assign unused_addr0 = download_addr[0];

    // The accumulator is valid exactly when any byte in it has been written.
    assign acc_v     = |acc_mask_q;
    assign out_free  = !out_v_q || !mem_waitReq;
    assign hit       = download_cs && download_wr && (download_index == ROM_INDEX);
    assign accept    = hit && !download_waitReq;
    assign merge_ok  = lat_v_q && (!acc_v || acc_waddr_q == lat_waddr_q);
    assign ins_mask  = lane_mask(lat_lane_q);
    assign ins_data  = lane_data(lat_lane_q, lat_data_q);
    // An empty accumulator contributes zeros so stale data never leaks into unwritten lanes.
    assign m_mask    = (acc_v ? acc_mask_q : '0) | ins_mask;
    assign m_data    = ((acc_v ? acc_data_q : '0) & ~lane_sel(lat_lane_q)) | ins_data;
    assign empty_all = !lat_v_q && !acc_v && !out_v_q;

    assign download_waitReq = lat_v_q || flush_q;
    assign mem_wr   = out_v_q;
    assign mem_addr = BASE_ADDR + 32'({out_waddr_q, 3'b000});
    assign mem_din  = out_data_q;
    assign mem_mask = out_mask_q;
    assign busy     = !empty_all;
    assign done     = flush_q && empty_all;
    assign error    = error_q;

    always_comb begin
        lat_v_d     = lat_v_q;
        lat_waddr_d = lat_waddr_q;
        lat_lane_d  = lat_lane_q;
        lat_data_d  = lat_data_q;
        acc_waddr_d = acc_waddr_q;
        acc_data_d  = acc_data_q;
        acc_mask_d  = acc_mask_q;
        out_v_d     = out_v_q && mem_waitReq;
        out_waddr_d = out_waddr_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        if (merge_ok) begin
            lat_v_d = 1'b0;
            // A write that completes the word bypasses the accumulator to keep latency at two cycles.
            if (&m_mask && out_free) begin
                out_v_d     = 1'b1;
                out_waddr_d = lat_waddr_q;
                out_data_d  = m_data;
                out_mask_d  = m_mask;
                acc_mask_d  = '0;
            end else begin
                acc_waddr_d = lat_waddr_q;
                acc_data_d  = m_data;
                acc_mask_d  = m_mask;
            end
        end else if (lat_v_q && out_free) begin
            // Word address changed: retire the old word and seed a new one from the latch.
            lat_v_d     = 1'b0;
            out_v_d     = 1'b1;
            out_waddr_d = acc_waddr_q;
            out_data_d  = acc_data_q;
            out_mask_d  = acc_mask_q;
            acc_waddr_d = lat_waddr_q;
            acc_data_d  = ins_data;
            acc_mask_d  = ins_mask;
        end else if (!lat_v_q && acc_v && out_free && (&acc_mask_q || flush_q)) begin
            out_v_d     = 1'b1;
            out_waddr_d = acc_waddr_q;
            out_data_d  = acc_data_q;
            out_mask_d  = acc_mask_q;
            acc_mask_d  = '0;
        end
        if (accept) begin
            lat_v_d     = 1'b1;
            lat_waddr_d = download_addr[26:3];
            lat_lane_d  = download_addr[2:1];
            lat_data_d  = download_dout;
        end
        flush_d = (cs_q && !download_cs) || (flush_q && !done);
        error_d = error_q || (hit && download_waitReq);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_v_q     <= 1'b0;
            lat_waddr_q <= '0;
            lat_lane_q  <= '0;
            lat_data_q  <= '0;
            acc_waddr_q <= '0;
            acc_data_q  <= '0;
            acc_mask_q  <= '0;
            out_v_q     <= 1'b0;
            out_waddr_q <= '0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            cs_q        <= 1'b0;
            flush_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            lat_v_q     <= lat_v_d;
            lat_waddr_q <= lat_waddr_d;
            lat_lane_q  <= lat_lane_d;
            lat_data_q  <= lat_data_d;
            acc_waddr_q <= acc_waddr_d;
            acc_data_q  <= acc_data_d;
            acc_mask_q  <= acc_mask_d;
            out_v_q     <= out_v_d;
            out_waddr_q <= out_waddr_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            cs_q        <= download_cs;
            flush_q     <= flush_d;
            error_q     <= error_d;
        end
    end
endmodule
